// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// =====================================================================
// lsu_mem_ctrl : load/store sequencer on a single-outstanding bus.
// Optional macro LSU_MISALIGN_CHECK_EN traps misaligned half/word/dword.
// Revision : 1.0
// =====================================================================
module lsu_mem_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ls_load_en,
  input  logic                ls_store_en,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_store_data,
  input  logic [1:0]          ls_data_type,
  input  logic                ls_load_unsigned,
  input  logic [4:0]          ls_rd_idx,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                ls_stall,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_load_data,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic                ls_misalign,
`endif
  output logic [4:0]          ls_load_rd_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                req;
  logic                misalign;
  logic [7:0]          strb_base;
  logic [7:0]          wstrb_in;
  logic [DATA_W-1:0]   wdata_in;
  logic [DATA_W-1:0]   rsp_shift;
  logic [DATA_W-1:0]   load_ext;

  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          type_q;
  logic                unsigned_q;
  logic [4:0]          rd_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wstrb_q;
  logic [DATA_W-1:0]   load_data_q;
  logic [4:0]          load_rd_q;
`ifdef LSU_MISALIGN_CHECK_EN
  logic                misalign_q;
`endif

  assign req = ls_load_en | ls_store_en;

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (ls_data_type)
      2'b01:   misalign = ls_addr[0];
      2'b10:   misalign = |ls_addr[1:0];
      2'b11:   misalign = |ls_addr[2:0];
      default: misalign = 1'b0;
    endcase
`endif
  end

  // Store lanes: strobes and data slide up by the byte offset; bytes past lane 7 fall off.
  always_comb begin
    case (ls_data_type)
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
    wstrb_in = ls_store_en ? (strb_base << ls_addr[2:0]) : 8'h00;
    wdata_in = ls_store_data << {ls_addr[2:0], 3'b000};
  end

  always_comb begin
    rsp_shift = mem_rsp_rdata >> {addr_q[2:0], 3'b000};
    case (type_q)
      2'b00:   load_ext = {{(DATA_W-8){~unsigned_q & rsp_shift[7]}},   rsp_shift[7:0]};
      2'b01:   load_ext = {{(DATA_W-16){~unsigned_q & rsp_shift[15]}}, rsp_shift[15:0]};
      2'b10:   load_ext = {{(DATA_W-32){~unsigned_q & rsp_shift[31]}}, rsp_shift[31:0]};
      default: load_ext = rsp_shift;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ls_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          ls_stall  = 1'b1;
          state_nxt = misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        ls_stall = 1'b1;
        if (mem_req_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        ls_stall = 1'b1;
        if (mem_rsp_valid) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      type_q      <= '0;
      unsigned_q  <= 1'b0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      load_data_q <= '0;
      load_rd_q   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        addr_q     <= ls_addr;
        type_q     <= ls_data_type;
        unsigned_q <= ls_load_unsigned;
        rd_q       <= ls_rd_idx;
        wen_q      <= ls_store_en;
        wdata_q    <= wdata_in;
        wstrb_q    <= wstrb_in;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_q <= misalign;
`endif
      end
      if (state == S_RESP && mem_rsp_valid && !wen_q) begin
        load_data_q <= load_ext;
        load_rd_q   <= rd_q;
      end
    end
  end

  assign mem_req_valid  = (state == S_REQ);
  assign mem_req_wen    = wen_q;
  assign mem_req_addr   = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign ls_done        = (state == S_DONE);
  assign ls_load_data   = load_data_q;
  assign ls_load_rd_idx = load_rd_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign ls_misalign    = (state == S_DONE) & misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// tb_lsu_mem_ctrl : directed + randomized bench checked against a byte-level model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ls_load_en, ls_store_en;
  logic [63:0] ls_addr, ls_store_data;
  logic [1:0]  ls_data_type;
  logic        ls_load_unsigned;
  logic [4:0]  ls_rd_idx;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        ls_stall, ls_done;
  logic [63:0] ls_load_data;
  logic [4:0]  ls_load_rd_idx;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        ls_misalign;
`endif

  lsu_mem_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ls_load_en(ls_load_en), .ls_store_en(ls_store_en),
    .ls_addr(ls_addr), .ls_store_data(ls_store_data),
    .ls_data_type(ls_data_type), .ls_load_unsigned(ls_load_unsigned),
    .ls_rd_idx(ls_rd_idx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .ls_stall(ls_stall), .ls_done(ls_done),
    .ls_load_data(ls_load_data),
`ifdef LSU_MISALIGN_CHECK_EN
    .ls_misalign(ls_misalign),
`endif
    .ls_load_rd_idx(ls_load_rd_idx)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations and architectural model state
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_done = 1'b0;
  logic        exp_zero = 1'b0, exp_wen = 1'b0, exp_mis = 1'b0;
  logic [63:0] exp_addr = '0, exp_wdata = '0;
  logic [7:0]  exp_wstrb = '0;
  logic [63:0] m_load_data = '0;
  logic [4:0]  m_rd = '0;
  logic        pin_req_en = 1'b0, pin_ld_en = 1'b0;
  logic [63:0] pin_addr = '0, pin_wdata = '0, pin_ldata = '0;
  logic [7:0]  pin_wstrb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic int size_of(input logic [1:0] t);
    return 1 << t;
  endfunction

  function automatic logic [7:0] m_strb(input logic [1:0] t, input logic [2:0] o);
    logic [7:0] s;
    int oi;
    s  = '0;
    oi = int'(o);
    for (int b = 0; b < 8; b++)
      if (b >= oi && b < oi + size_of(t)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [2:0] o);
    logic [63:0] w;
    int oi;
    w  = '0;
    oi = int'(o);
    for (int b = 0; b < 8; b++)
      if (b >= oi) w[8*b +: 8] = d[8*(b-oi) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] r, input logic [2:0] o,
                                         input logic [1:0] t, input logic uns);
    logic [63:0] v;
    int oi, n;
    v  = '0;
    oi = int'(o);
    n  = size_of(t);
    for (int k = 0; k < n; k++)
      if (oi + k < 8) v[8*k +: 8] = r[8*(oi+k) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic m_misaligned(input logic [1:0] t, input logic [63:0] a);
    return (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00) ||
           (t == 2'b11 && a[2:0] != 3'b000);
  endfunction
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ls_stall", {63'd0, ls_stall}, {63'd0, exp_stall});
      chk("mem_req_valid", {63'd0, mem_req_valid}, {63'd0, exp_valid});
      chk("ls_done", {63'd0, ls_done}, {63'd0, exp_done});
      chk("ls_load_data", ls_load_data, m_load_data);
      chk("ls_load_rd_idx", {59'd0, ls_load_rd_idx}, {59'd0, m_rd});
      if (exp_valid) begin
        chk("req_addr", mem_req_addr, exp_addr);
        chk("req_wen", {63'd0, mem_req_wen}, {63'd0, exp_wen});
        chk("req_wstrb", {56'd0, mem_req_wstrb}, {56'd0, exp_wstrb});
        if (exp_wen) chk("req_wdata", mem_req_wdata, exp_wdata);
      end
      if (exp_zero) begin
        chk("zero_addr", mem_req_addr, 64'd0);
        chk("zero_wdata", mem_req_wdata, 64'd0);
        chk("zero_wstrb", {56'd0, mem_req_wstrb}, 64'd0);
        chk("zero_wen", {63'd0, mem_req_wen}, 64'd0);
      end
      if (pin_req_en && exp_valid) begin
        chk("pin_addr", mem_req_addr, pin_addr);
        chk("pin_wstrb", {56'd0, mem_req_wstrb}, {56'd0, pin_wstrb});
        chk("pin_wdata", mem_req_wdata, pin_wdata);
      end
      if (pin_ld_en && exp_done) chk("pin_load_data", ls_load_data, pin_ldata);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("ls_misalign", {63'd0, ls_misalign}, {63'd0, exp_mis});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ls_load_en    = 1'b0;
      ls_store_en   = 1'b0;
      exp_stall     = 1'b0;
      exp_valid     = 1'b0;
      exp_done      = 1'b0;
      mem_req_ready = rbit();
      mem_rsp_valid = rbit();
      mem_rsp_rdata = {$urandom, $urandom};
      step();
    end
  endtask

  // Drives one access; rdly = cycles ready is held low, sdly = extra cycles before response.
  task automatic run_txn(input logic ld, input logic st, input logic [63:0] a,
                         input logic [63:0] d, input logic [1:0] t, input logic uns,
                         input logic [4:0] rd, input int rdly, input int sdly,
                         input logic [63:0] rdata);
    ls_load_en       = ld;
    ls_store_en      = st;
    ls_addr          = a;
    ls_store_data    = d;
    ls_data_type     = t;
    ls_load_unsigned = uns;
    ls_rd_idx        = rd;
    mem_req_ready    = rbit();
    mem_rsp_valid    = rbit();
    exp_addr         = {a[63:3], 3'b000};
    exp_wen          = st;
    exp_wstrb        = st ? m_strb(t, a[2:0]) : 8'h00;
    exp_wdata        = m_wdata(d, a[2:0]);
    exp_stall        = 1'b1;
    exp_valid        = 1'b0;
    exp_done         = 1'b0;
    exp_mis          = 1'b0;
    step();
`ifdef LSU_MISALIGN_CHECK_EN
    if (m_misaligned(t, a)) begin
      exp_stall     = 1'b0;
      exp_done      = 1'b1;
      exp_mis       = 1'b1;
      mem_rsp_valid = rbit();
      step();
      exp_done = 1'b0;
      exp_mis  = 1'b0;
      return;
    end
`endif
    for (int i = 0; i <= rdly; i++) begin
      exp_valid     = 1'b1;
      mem_req_ready = (i == rdly);
      mem_rsp_valid = rbit();
      mem_rsp_rdata = {$urandom, $urandom};
      step();
    end
    exp_valid = 1'b0;
    for (int i = 0; i <= sdly; i++) begin
      mem_req_ready = rbit();
      mem_rsp_valid = (i == sdly);
      mem_rsp_rdata = (i == sdly) ? rdata : {$urandom, $urandom};
      step();
    end
    if (!st) begin
      m_load_data = m_load(rdata, a[2:0], t, uns);
      m_rd        = rd;
    end
    exp_stall     = 1'b0;
    exp_done      = 1'b1;
    mem_rsp_valid = rbit();
    mem_req_ready = rbit();
    step();
    exp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld, st;
    int          sel;
    rst              = 1'b1;
    ls_load_en       = 1'b0;
    ls_store_en      = 1'b0;
    ls_addr          = '0;
    ls_store_data    = '0;
    ls_data_type     = 2'b00;
    ls_load_unsigned = 1'b0;
    ls_rd_idx        = '0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_rdata    = '0;
    repeat (3) step();
    rst      = 1'b0;
    chk_en   = 1'b1;
    exp_zero = 1'b1;
    idle(2);
    exp_zero = 1'b0;

    // Reset while waiting for the response; the late response must be ignored
    ls_load_en = 1'b1; ls_store_en = 1'b0; ls_addr = 64'h8000_0040;
    ls_data_type = 2'b11; ls_rd_idx = 5'd9; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_addr = 64'h8000_0040; exp_wen = 1'b0; exp_wstrb = 8'h00;
    exp_stall = 1'b1; exp_valid = 1'b0; exp_done = 1'b0;
    step();
    exp_valid = 1'b1; mem_req_ready = 1'b1;
    step();
    exp_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ls_load_en = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    m_load_data = '0; m_rd = '0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_zero = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    step();
    exp_zero = 1'b0;

    // Store byte 0xAB at 0x80000003
    pin_req_en = 1'b1; pin_addr = 64'h8000_0000; pin_wstrb = 8'h08;
    pin_wdata = 64'h0000_0000_AB00_0000;
    run_txn(1'b0, 1'b1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 2'b00, 1'b0, 5'd3, 0, 0, '0);
    pin_req_en = 1'b0;
    idle(1);

    // Signed then unsigned half load at 0x80000006
    pin_ld_en = 1'b1; pin_ldata = 64'hFFFF_FFFF_FFFF_8001;
    run_txn(1'b1, 1'b0, 64'h8000_0006, '0, 2'b01, 1'b0, 5'd7, 0, 0, 64'h8001_0000_0000_0000);
    pin_ldata = 64'h0000_0000_0000_8001;
    run_txn(1'b1, 1'b0, 64'h8000_0006, '0, 2'b01, 1'b1, 5'd12, 0, 0, 64'h8001_0000_0000_0000);
    pin_ld_en = 1'b0;
    idle(1);

    // Backpressure: ready low for five cycles
    pin_req_en = 1'b1; pin_addr = 64'h8000_0008; pin_wstrb = 8'hFF;
    pin_wdata = 64'h1122_3344_5566_7788;
    run_txn(1'b0, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 2'b11, 1'b0, 5'd1, 5, 2, '0);
    pin_req_en = 1'b0;
    idle(1);

    // Back-to-back load dword then store word
    run_txn(1'b1, 1'b0, 64'h8000_0010, '0, 2'b11, 1'b1, 5'd20, 0, 0, 64'hCAFE_F00D_1234_5678);
    pin_req_en = 1'b1; pin_addr = 64'h8000_0020; pin_wstrb = 8'h0F;
    pin_wdata = 64'h0000_0000_DEAD_BEEF;
    run_txn(1'b0, 1'b1, 64'h8000_0020, 64'h0000_0000_DEAD_BEEF, 2'b10, 1'b0, 5'd4, 0, 0, '0);
    pin_req_en = 1'b0;
    idle(1);

`ifdef LSU_MISALIGN_CHECK_EN
    run_txn(1'b1, 1'b0, 64'h8000_0002, '0, 2'b10, 1'b0, 5'd15, 0, 0, 64'h1111_2222_3333_4444);
    idle(1);
`endif

    // Randomized traffic, including both-enables and misaligned offsets
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 2);
      ld  = (sel != 1);
      st  = (sel != 0);
      run_txn(ld, st, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              rbit(), 5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom});
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
